// File: rtl/shim_thresh_integrator.sv
// rtl/shim_thresh_integrator.sv - windowed |sample| integrator with average-threshold fault detection
// Optional build macro SHIM_INTEG_PEAK_TRACK_EN adds per-window peak |sample| capture on peak_abs.
module shim_thresh_integrator #(
    parameter int SAMPLE_W = 16
) (
    input  logic                spi_clk,
    input  logic                resetn,
    input  logic [14:0]         integ_thresh_avg,
    input  logic [31:0]         integ_window,
    input  logic                integ_en,
    input  logic                spi_en,
    input  logic [SAMPLE_W-1:0] sample,
    input  logic                sample_valid,
    output logic                setup_done,
    output logic                window_done,
    output logic                over_thresh,
    output logic                cfg_err,
    output logic [SAMPLE_W-1:0] peak_abs
);
    localparam int ACC_W = SAMPLE_W + 32;
    localparam int CMP_W = (ACC_W > 47) ? ACC_W : 47;

    typedef enum logic [1:0] {IDLE, SETUP, RUN, FAULT} state_t;

    state_t              r_state, w_state_nxt;
    logic [31:0]         r_window, r_count, w_count_inc;
    logic [14:0]         r_thresh;
    logic [46:0]         r_thresh_sum, w_pp;
    logic [4:0]          r_mul_cnt;
    logic [ACC_W-1:0]    r_acc, w_acc_sum;
    logic [SAMPLE_W-1:0] w_abs;
    logic                r_window_done, r_over_thresh, r_cfg_err;
    logic                w_abort, w_close, w_over;

    // Most-negative input maps to 2^(SAMPLE_W-1), which still fits unsigned.
    assign w_abs       = sample[SAMPLE_W-1] ? (SAMPLE_W'(0) - sample) : sample;
    assign w_acc_sum   = r_acc + ACC_W'(w_abs);
    assign w_count_inc = r_count + 32'd1;
    assign w_close     = (r_state == RUN) && sample_valid && (w_count_inc == r_window);
    assign w_over      = CMP_W'(w_acc_sum) > CMP_W'(r_thresh_sum);
    assign w_pp        = r_window[r_mul_cnt] ? ({32'd0, r_thresh} << r_mul_cnt) : 47'd0;
    assign w_abort     = !spi_en || (!integ_en && (r_state == SETUP || r_state == RUN));

    always_ff @(posedge spi_clk or negedge resetn) begin
        if (!resetn) r_state <= IDLE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_abort) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE:    if (integ_en) w_state_nxt = SETUP;
                SETUP: begin
                    if (r_mul_cnt == 5'd0 && r_window < 32'd2) w_state_nxt = FAULT;
                    else if (r_mul_cnt == 5'd31)               w_state_nxt = RUN;
                end
                RUN:     if (w_close && w_over) w_state_nxt = FAULT;
                default: w_state_nxt = r_state;
            endcase
        end
    end

    always_ff @(posedge spi_clk or negedge resetn) begin
        if (!resetn) begin
            r_window      <= '0;
            r_thresh      <= '0;
            r_thresh_sum  <= '0;
            r_mul_cnt     <= '0;
            r_acc         <= '0;
            r_count       <= '0;
            r_window_done <= 1'b0;
            r_over_thresh <= 1'b0;
            r_cfg_err     <= 1'b0;
        end else begin
            r_window_done <= 1'b0;
            if (w_abort) begin
                r_thresh_sum  <= '0;
                r_mul_cnt     <= '0;
                r_acc         <= '0;
                r_count       <= '0;
                r_over_thresh <= 1'b0;
                r_cfg_err     <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: if (integ_en) begin
                        r_window     <= integ_window;
                        r_thresh     <= integ_thresh_avg;
                        r_thresh_sum <= '0;
                        r_mul_cnt    <= '0;
                    end
                    SETUP: begin
                        if (r_mul_cnt == 5'd0 && r_window < 32'd2) begin
                            r_cfg_err <= 1'b1;
                        end else begin
                            r_thresh_sum <= r_thresh_sum + w_pp;
                            r_mul_cnt    <= r_mul_cnt + 5'd1;
                        end
                    end
                    RUN: if (sample_valid) begin
                        if (w_close) begin
                            if (w_over) begin
                                r_over_thresh <= 1'b1;
                            end else begin
                                r_window_done <= 1'b1;
                                r_acc         <= '0;
                                r_count       <= '0;
                            end
                        end else begin
                            r_acc   <= w_acc_sum;
                            r_count <= w_count_inc;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign setup_done  = (r_state == RUN);
    assign window_done = r_window_done;
    assign over_thresh = r_over_thresh;
    assign cfg_err     = r_cfg_err;

`ifdef SHIM_INTEG_PEAK_TRACK_EN
    logic [SAMPLE_W-1:0] r_peak_run, r_peak_abs, w_peak_nxt;

    assign w_peak_nxt = (w_abs > r_peak_run) ? w_abs : r_peak_run;

    // Captured on every close, faulting or not; running max restarts each window.
    always_ff @(posedge spi_clk or negedge resetn) begin
        if (!resetn) begin
            r_peak_run <= '0;
            r_peak_abs <= '0;
        end else if (w_abort || r_state == IDLE) begin
            r_peak_run <= '0;
            r_peak_abs <= '0;
        end else if (r_state == RUN && sample_valid) begin
            if (w_close) begin
                r_peak_abs <= w_peak_nxt;
                r_peak_run <= '0;
            end else begin
                r_peak_run <= w_peak_nxt;
            end
        end
    end

    assign peak_abs = r_peak_abs;
`else
    assign peak_abs = '0;
`endif
endmodule

// File: doc/shim_thresh_integrator.md
SHIM_THRESH_INTEGRATOR -- requirements
Module: shim_thresh_integrator

Interface
REQ-001 The block SHALL have parameter SAMPLE_W, default 16: signed sample width; allowed range 8..16.
REQ-002 The block SHALL have port spi_clk, input, width 1: the single clock; all logic is on its rising edge.
REQ-003 The block SHALL have port resetn, input, width 1: reset, asynchronous and active-low.
REQ-004 The block SHALL have port integ_thresh_avg, input, width 15: average |sample| threshold (spi_clk-stable config).
REQ-005 The block SHALL have port integ_window, input, width 32: samples per integration window.
REQ-006 The block SHALL have port integ_en, input, width 1: enables threshold checking.
REQ-007 The block SHALL have port spi_en, input, width 1: enables the block; a low level aborts operation.
REQ-008 The block SHALL have port sample, input, width SAMPLE_W: two's-complement DAC/ADC sample.
REQ-009 The block SHALL have port sample_valid, input, width 1: qualifies sample for one cycle.
REQ-010 The block SHALL have port setup_done, output, width 1: high while in RUN.
REQ-011 The block SHALL have port window_done, output, width 1: one-cycle pulse when a window closes without fault.
REQ-012 The block SHALL have port over_thresh, output, width 1: sticky fault, window average exceeded threshold.
REQ-013 The block SHALL have port cfg_err, output, width 1: sticky, integ_window < 2 at setup.
REQ-014 The block SHALL have port peak_abs, output, width SAMPLE_W: maximum |sample| of the last closed window.

Function
REQ-015 The block SHALL implement exactly these states: IDLE, SETUP, RUN, FAULT.
REQ-016 IDLE->SETUP SHALL occur when spi_en=1 and integ_en=1; if spi_en=1 and integ_en=0, the block SHALL stay in IDLE with all outputs 0.
REQ-017 On SETUP entry, the block SHALL latch integ_window and integ_thresh_avg; config changes afterwards SHALL be ignored until the next IDLE.
REQ-018 If the latched window < 2, SETUP SHALL go to FAULT in 1 cycle with cfg_err=1.
REQ-019 Otherwise, SETUP SHALL compute thresh_sum = thresh * window (47-bit, unsigned) with a shift-add multiplier taking exactly 32 cycles, then enter RUN.
REQ-020 In RUN, each sample_valid SHALL add |sample| (SAMPLE_W bits unsigned; most-negative input maps to 2^(SAMPLE_W-1)) to an accumulator of SAMPLE_W+32 bits, which never wraps.
REQ-021 In RUN, a sample counter SHALL increment per valid sample; sample_valid outside RUN SHALL be ignored.
REQ-022 On the valid sample making count = window, the block SHALL compare (acc + |sample|) > thresh_sum.
REQ-023 If that compare is true, the next cycle SHALL have over_thresh=1 and state FAULT.
REQ-024 If that compare is false, the next cycle SHALL pulse window_done=1 and clear acc and count, so the following window starts at count 0.
REQ-025 Equality with thresh_sum SHALL NOT be a fault.
REQ-026 A sample arriving on the cycle after a window closes SHALL be counted in the new window, with no gap cycle required.
REQ-027 FAULT SHALL hold over_thresh/cfg_err and ignore samples until spi_en=0.
REQ-028 spi_en=0 in any state SHALL force IDLE on the next cycle, clearing acc, count, flags and setup_done.
REQ-029 Dropping integ_en in SETUP/RUN SHALL behave identically to spi_en=0.
REQ-030 When spi_en falls coincident with a window-closing sample, abort SHALL take priority: no fault and no window_done.

Reset
REQ-031 resetn=0 SHALL asynchronously force IDLE, clearing acc, count, multiplier and latched config, and setting setup_done=0, window_done=0, over_thresh=0, cfg_err=0, peak_abs=0.
REQ-032 After reset release, the first transition SHALL occur no earlier than the first spi_clk edge with resetn=1.
REQ-033 Reset mid-SETUP or mid-RUN SHALL leave no residual partial product or partial sum.

Configuration
REQ-034 With macro SHIM_INTEG_PEAK_TRACK_EN defined, the block SHALL track the running max |sample| per window and load it into peak_abs on each window close, both fault and non-fault.
REQ-035 peak_abs SHALL hold its value until the next close or IDLE (IDLE clears it to 0).
REQ-036 Without SHIM_INTEG_PEAK_TRACK_EN, peak_abs SHALL be constant 0 and no peak register shall be synthesized.

Verification
REQ-037 The bench SHALL cover: window=4, thresh=100, samples 100,-100,100,-100 -> no fault, window_done pulse 1 cycle after 4th sample, setup_done high 33 cycles after spi_en.
REQ-038 The bench SHALL cover: window=4, thresh=100, samples 100,100,100,101 -> over_thresh=1 cycle after 4th sample, state FAULT, later samples ignored.
REQ-039 The bench SHALL cover: window=1 at SETUP -> cfg_err=1 after 1 cycle; spi_en low -> all flags 0 next cycle.
REQ-040 The bench SHALL cover: window=2^32-1, thresh=32767, continuous samples of -32768 (SAMPLE_W=16) -> no accumulator wrap, fault on window close.
REQ-041 The bench SHALL cover: spi_en dropped on the 4th (closing) sample -> no window_done, no over_thresh, IDLE next cycle.
REQ-042 The bench SHALL cover: with SHIM_INTEG_PEAK_TRACK_EN, samples 3,-9,5,1 -> peak_abs=9 after close; resetn pulse mid-RUN -> all outputs 0 immediately.
